// File: rtl/chain_tx_scheduler.sv
// chain_tx_scheduler: buffers chain codes and frames each contour as HEADER, codes, [XOR checksum], TRAILER for a UART TX.
// The checksum byte exists only when CHAIN_TX_CHECKSUM_EN is defined; in_ready drops only while the payload FIFO is full.
module chain_tx_scheduler #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter logic [7:0] TRAILER    = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       frame_done,
  output logic       code_err
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
`ifdef CHAIN_TX_CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_TRL  = 3'd4
  } state_t;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          fifo_full, fifo_empty, code_ok, push, pop, slot_ok;
  logic [8:0]    head;

  state_t        state_q;
  logic          tx_start_q, frame_done_q, code_err_q;
  logic [7:0]    tx_data_q;

  assign fifo_full  = (cnt_q == DEPTH_L);
  assign fifo_empty = (cnt_q == '0);
  assign in_ready   = !fifo_full;
  assign code_ok    = (in_data[7:3] == 5'd0);
  assign push       = in_valid && in_ready && code_ok;
  assign head       = mem_q[rd_ptr_q];

  // The serializer raises busy only the cycle after our pulse, so the pulse cycle itself is a holdoff.
  assign slot_ok = !tx_busy && !tx_start_q;
  assign pop     = (state_q == S_DATA) && slot_ok && !fifo_empty;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

`ifdef CHAIN_TX_CHECKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == S_IDLE) begin
      chk_q <= '0;
    end else if (pop) begin
      chk_q <= chk_q ^ head[7:0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (in_valid && in_ready && !code_ok) code_err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            if (slot_ok) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= HEADER;
              state_q    <= S_DATA;
            end else begin
              state_q <= S_HDR;
            end
          end
        end
        S_HDR: begin
          if (slot_ok) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= HEADER;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          if (pop) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= head[7:0];
            if (head[8]) begin
`ifdef CHAIN_TX_CHECKSUM_EN
              state_q <= S_CHK;
`else
              state_q <= S_TRL;
`endif
            end
          end
        end
`ifdef CHAIN_TX_CHECKSUM_EN
        S_CHK: begin
          if (slot_ok) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= chk_q;
            state_q    <= S_TRL;
          end
        end
`endif
        S_TRL: begin
          if (slot_ok) begin
            tx_start_q   <= 1'b1;
            tx_data_q    <= TRAILER;
            frame_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign frame_done = frame_done_q;
  assign code_err   = code_err_q;

endmodule

// File: tb/tb_chain_tx_scheduler.sv
// Randomized bench for chain_tx_scheduler: a serializer model answers tx_start with tx_busy, and a frame-level reference predicts the byte stream.
module tb_chain_tx_scheduler;

  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] TRL = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       frame_done;
  logic       code_err;

  chain_tx_scheduler dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .frame_done(frame_done), .code_err(code_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Serializer model and monitor state
  int         busy_len = 4;
  bit         busy_stuck = 1'b0;
  int         ser_cnt = 0;
  int         proto_viol = 0;
  int         frame_cnt = 0;
  bit         stab_ok = 1'b0;
  logic [7:0] last_byte = '0;
  logic [7:0] got_q[$];

  // Reference model state
  logic [7:0] cur_q[$];
  logic [7:0] exp_q[$];
  int         exp_frames = 0;
  bit         exp_err = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stab_ok = 1'b0;
    end else begin
      if (tx_start) begin
        if (ser_cnt != 0 || tx_busy) proto_viol++;
        got_q.push_back(tx_data);
        last_byte = tx_data;
        stab_ok   = 1'b1;
        if (frame_done && tx_data !== TRL) proto_viol++;
      end else if (stab_ok && ser_cnt != 0 && tx_data !== last_byte) begin
        proto_viol++;
      end
      if (frame_done) begin
        frame_cnt++;
        if (!tx_start) proto_viol++;
      end
    end
    if (ser_cnt > 0) ser_cnt--;
    if (tx_start && !rst) ser_cnt = busy_len + 1;
    tx_busy = busy_stuck || (ser_cnt > 0 && ser_cnt <= busy_len);
  end

  function automatic void model_accept(input logic [7:0] d, input logic l);
    logic [7:0] x;
    if (d > 8'd7) begin
      exp_err = 1'b1;
      return;
    end
    cur_q.push_back(d);
    if (l) begin
      x = '0;
      exp_q.push_back(HDR);
      foreach (cur_q[i]) begin
        exp_q.push_back(cur_q[i]);
        x ^= cur_q[i];
      end
`ifdef CHAIN_TX_CHECKSUM_EN
      exp_q.push_back(x);
`endif
      exp_q.push_back(TRL);
      exp_frames++;
      cur_q.delete();
    end
  endfunction

  function automatic int first_diff();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    logic [7:0] r = 'x;
    if (i >= 0 && i < got_q.size()) r = got_q[i];
    return r;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    logic [7:0] r = 'x;
    if (i >= 0 && i < exp_q.size()) r = exp_q[i];
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_code(input logic [7:0] d, input logic l);
    int n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready || n >= 5000) break;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout in_ready %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(d, l);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (!(frame_cnt >= exp_frames && ser_cnt == 0) && n < budget) begin
      cyc(1);
      n++;
    end
    ok = (frame_cnt >= exp_frames && ser_cnt == 0);
    cyc(6);
  endtask

  task automatic do_reset();
    int n = 0;
    busy_stuck = 1'b0;
    in_valid   = 1'b0;
    while (ser_cnt != 0 && n < 500) begin
      cyc(1);
      n++;
    end
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    cur_q.delete();
    exp_frames = 0;
    exp_err    = 1'b0;
    frame_cnt  = 0;
    proto_viol = 0;
  endtask

  task automatic test_reset();
    cyc(3);
    rst = 1'b0;
    checks++; if (tx_start !== 1'b0)   begin errors++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
    checks++; if (tx_data !== 8'h00)   begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (code_err !== 1'b0)   begin errors++; $display("FAIL reset_code_err got %b exp 0", code_err); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    bit ok;
    int di;
    do_reset();
    busy_len = 10;
    push_code(8'd3, 1'b1);
    wait_idle(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout frames %0d exp %0d", frame_cnt, exp_frames); end
    di = first_diff();
    checks++;
    if (di >= 0) begin
      errors++;
      $display("FAIL single_stream idx %0d got %h exp %h len %0d exp_len %0d", di, got_at(di), exp_at(di), got_q.size(), exp_q.size());
    end
    checks++; if (frame_cnt !== 1) begin errors++; $display("FAIL single_frame_done got %0d exp 1", frame_cnt); end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL single_protocol got %0d violations exp 0", proto_viol); end
  endtask

  task automatic test_full();
    bit ok;
    int di;
    int n = 0;
    logic [7:0] d;
    do_reset();
    busy_len   = $urandom_range(1, 4);
    busy_stuck = 1'b1;
    cyc(2);
    for (int i = 0; i < 16; i++) push_code(8'($urandom_range(0, 7)), i == 15);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    cyc(1);
    d = 8'($urandom_range(0, 7));
    in_data  = d;
    in_last  = 1'b1;
    in_valid = 1'b1;
    cyc(5);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_hold_in_ready got %b exp 0", in_ready); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL full_sent_while_busy got %0d bytes exp 0", got_q.size()); end
    busy_stuck = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready || n >= 5000) break;
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(d, 1'b1);
    wait_idle(5000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout frames %0d exp %0d", frame_cnt, exp_frames); end
    di = first_diff();
    checks++;
    if (di >= 0) begin
      errors++;
      $display("FAIL full_stream idx %0d got %h exp %h len %0d exp_len %0d", di, got_at(di), exp_at(di), got_q.size(), exp_q.size());
    end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL full_protocol got %0d violations exp 0", proto_viol); end
  endtask

  task automatic test_gap();
    bit ok;
    int di;
    do_reset();
    busy_len = $urandom_range(0, 6);
    push_code(8'd1, 1'b0);
    push_code(8'd2, 1'b0);
    cyc(40);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL gap_before got %0d bytes exp 3", got_q.size()); end
    cyc(30);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL gap_idle got %0d bytes exp 3", got_q.size()); end
    push_code(8'd7, 1'b1);
    wait_idle(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gap_timeout frames %0d exp %0d", frame_cnt, exp_frames); end
    di = first_diff();
    checks++;
    if (di >= 0) begin
      errors++;
      $display("FAIL gap_stream idx %0d got %h exp %h len %0d exp_len %0d", di, got_at(di), exp_at(di), got_q.size(), exp_q.size());
    end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL gap_protocol got %0d violations exp 0", proto_viol); end
  endtask

  task automatic test_code_err();
    bit ok;
    int di;
    do_reset();
    busy_len = $urandom_range(1, 6);
    push_code(8'd2, 1'b0);
    push_code(8'h09, 1'b0);
    checks++; if (code_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", code_err); end
    push_code(8'd5, 1'b1);
    wait_idle(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_timeout frames %0d exp %0d", frame_cnt, exp_frames); end
    di = first_diff();
    checks++;
    if (di >= 0) begin
      errors++;
      $display("FAIL err_stream idx %0d got %h exp %h len %0d exp_len %0d", di, got_at(di), exp_at(di), got_q.size(), exp_q.size());
    end
    checks++; if (code_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", code_err); end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    do_reset();
    busy_len = 8;
    push_code(8'd1, 1'b0);
    push_code(8'd2, 1'b0);
    push_code(8'd3, 1'b1);
    while (got_q.size() < 1 && n < 200) begin
      cyc(1);
      n++;
    end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL midrst_header got %0d bytes exp 1", got_q.size()); end
    rst = 1'b1;
    cyc(1);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL midrst_tx_start got %b exp 0", tx_start); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data got %h exp 00", tx_data); end
    rst = 1'b0;
    cyc(60);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL midrst_abandon got %0d bytes exp 1", got_q.size()); end
    checks++; if (frame_cnt != 0) begin errors++; $display("FAIL midrst_frame_done got %0d exp 0", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int di;
    int len;
    do_reset();
    busy_len = $urandom_range(0, 4);
    for (int c = 0; c < 2; c++) begin
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) push_code(8'($urandom_range(0, 7)), i == len - 1);
    end
    wait_idle(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout frames %0d exp %0d", frame_cnt, exp_frames); end
    di = first_diff();
    checks++;
    if (di >= 0) begin
      errors++;
      $display("FAIL b2b_stream idx %0d got %h exp %h len %0d exp_len %0d", di, got_at(di), exp_at(di), got_q.size(), exp_q.size());
    end
    checks++; if (frame_cnt != 2) begin errors++; $display("FAIL b2b_frames got %0d exp 2", frame_cnt); end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL b2b_protocol got %0d violations exp 0", proto_viol); end
  endtask

  task automatic test_random();
    bit ok;
    int di;
    int len;
    do_reset();
    busy_len = $urandom_range(0, 5);
    for (int c = 0; c < 6; c++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) push_code(8'($urandom_range(8, 255)), 1'b0);
        push_code(8'($urandom_range(0, 7)), i == len - 1);
        cyc($urandom_range(0, 3));
      end
    end
    wait_idle(5000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_timeout frames %0d exp %0d", frame_cnt, exp_frames); end
    di = first_diff();
    checks++;
    if (di >= 0) begin
      errors++;
      $display("FAIL rand_stream idx %0d got %h exp %h len %0d exp_len %0d", di, got_at(di), exp_at(di), got_q.size(), exp_q.size());
    end
    checks++; if (code_err !== exp_err) begin errors++; $display("FAIL rand_code_err got %b exp %b", code_err, exp_err); end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL rand_protocol got %0d violations exp 0", proto_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_gap();
    test_code_err();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
